// File: rtl/hyperbus_rx_deser_if.sv
// rtl/hyperbus_rx_deser_if.sv - captured DDR halfword input and assembled word output stream
interface hyperbus_rx_deser_if;
  logic        rx_valid_i;
  logic [7:0]  rx_d0_i;
  logic [7:0]  rx_d1_i;
  logic        word_valid_o;
  logic        word_ready_i;
  logic [31:0] word_data_o;
  logic        word_last_o;

  modport slave (
    input  rx_valid_i, rx_d0_i, rx_d1_i, word_ready_i,
    output word_valid_o, word_data_o, word_last_o
  );

  modport master (
    output rx_valid_i, rx_d0_i, rx_d1_i, word_ready_i,
    input  word_valid_o, word_data_o, word_last_o
  );
endinterface

// File: rtl/hyperbus_rx_deser.sv
// rtl/hyperbus_rx_deser.sv - HyperBus read deserializer: halfword pairs into 32-bit words via a FIFO
// Optional macro HYPERBUS_RX_ERR_CNT_EN adds err_cnt_o, a saturating count of dropped words.
module hyperbus_rx_deser #(
  parameter int FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [15:0]          len_i,
  hyperbus_rx_deser_if.slave   bus,
  output logic                 busy_o,
  output logic                 overflow_o
`ifdef HYPERBUS_RX_ERR_CNT_EN
  ,
  output logic [7:0]           err_cnt_o
`endif
);
  localparam int AW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FifoDepth);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  state_t        r_state;
  logic [15:0]   r_len;
  logic [15:0]   r_hw_cnt;
  logic [15:0]   r_lo;
  logic          r_overflow;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [32:0]   r_mem [FifoDepth];

  logic [15:0]   w_hw;
  logic [15:0]   w_hw_cnt_nxt;
  logic          w_rx;
  logic          w_final;
  logic          w_push;
  logic [31:0]   w_word;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;

  assign w_hw         = {bus.rx_d1_i, bus.rx_d0_i};
  assign w_hw_cnt_nxt = r_hw_cnt + 16'd1;
  assign w_rx         = (r_state == RECV) && bus.rx_valid_i;
  assign w_final      = (w_hw_cnt_nxt == r_len);
  // An odd counter means a low halfword is already held, so this one completes the pair.
  assign w_push       = w_rx && (r_hw_cnt[0] || w_final);
  assign w_word       = r_hw_cnt[0] ? {w_hw, r_lo} : {16'h0000, w_hw};
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == FULL_CNT);
  assign w_pop        = !w_empty && bus.word_ready_i;
  assign w_wr         = w_push && (!w_full || w_pop);
  assign w_drop       = w_push && !w_wr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_len      <= 16'h0000;
      r_hw_cnt   <= 16'h0000;
      r_lo       <= 16'h0000;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_overflow <= 1'b0;
            r_hw_cnt   <= 16'h0000;
            r_len      <= len_i;
            if (len_i != 16'h0000) r_state <= RECV;
          end
        end
        RECV: begin
          if (bus.rx_valid_i) begin
            r_hw_cnt <= w_hw_cnt_nxt;
            if (!r_hw_cnt[0]) r_lo <= w_hw;
            if (w_final) r_state <= DRAIN;
          end
          if (w_drop) r_overflow <= 1'b1;
        end
        DRAIN: begin
          if (w_empty) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // When full, a simultaneous pop frees the read slot, which is exactly the slot written here.
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= {w_final, w_word};
  end

`ifdef HYPERBUS_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_cnt <= 8'h00;
    end else if (w_drop && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'h01;
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

  assign bus.word_valid_o = !w_empty;
  assign bus.word_data_o  = w_empty ? 32'h0000_0000 : r_mem[r_rd_ptr][31:0];
  assign bus.word_last_o  = w_empty ? 1'b0 : r_mem[r_rd_ptr][32];
  assign busy_o           = (r_state != IDLE);
  assign overflow_o       = r_overflow;
endmodule
